// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg
// Types, register-map constants and helpers shared by the data-memory
// responder and its timer. Map constants come from dmem_map_def.v so the
// core-side define files and this RTL stay in lockstep.
`include "dmem_map_def.v"

package dmem_responder_pkg;

    localparam logic [5:0] OFF_CYCLE   = `DMEM_OFF_CYCLE;
    localparam logic [5:0] OFF_TCNT    = `DMEM_OFF_TCNT;
    localparam logic [5:0] OFF_TCMP    = `DMEM_OFF_TCMP;
    localparam logic [5:0] OFF_TCTRL   = `DMEM_OFF_TCTRL;
    localparam logic [5:0] OFF_STAT    = `DMEM_OFF_STAT;
    localparam logic [5:0] OFF_SCRATCH = `DMEM_OFF_SCRATCH;

    localparam int TCTRL_EN   = `DMEM_TCTRL_EN;
    localparam int TCTRL_AUTO = `DMEM_TCTRL_AUTO;
    localparam int TCTRL_IE   = `DMEM_TCTRL_IE;

    localparam int STAT_MATCH = `DMEM_STAT_MATCH;
    localparam int STAT_ERR   = `DMEM_STAT_ERR;

    // Which target the current address decodes to.
    typedef enum logic [1:0] {
        REGION_NONE = 2'd0,
        REGION_RAM  = 2'd1,
        REGION_MMIO = 2'd2
    } region_e;

    // Replace the enabled byte lanes of old_val with those of new_val.
    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  be
    );
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_val[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_map_def.v
// dmem_map_def.v
// Shared register-map definitions for the data-memory responder.
// MMIO word offsets are addr[7:2] inside the 256-byte register window.
`ifndef DMEM_MAP_DEF_V
`define DMEM_MAP_DEF_V

// MMIO word offsets
`define DMEM_OFF_CYCLE    6'd0
`define DMEM_OFF_TCNT     6'd1
`define DMEM_OFF_TCMP     6'd2
`define DMEM_OFF_TCTRL    6'd3
`define DMEM_OFF_STAT     6'd4
`define DMEM_OFF_SCRATCH  6'd5

// TCTRL bit positions
`define DMEM_TCTRL_EN     0
`define DMEM_TCTRL_AUTO   1
`define DMEM_TCTRL_IE     2

// STAT bit positions
`define DMEM_STAT_MATCH   0
`define DMEM_STAT_ERR     1

`endif

// File: rtl/dmem_timer.sv
// dmem_timer
// Compare timer of the MMIO bank: TCNT, TCMP, TCTRL, the STAT.MATCH flag
// and the level interrupt derived from it.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   tcnt_we..stat_we    qualified (aligned, committed) register writes
//   wdata, wbe          write data and byte-lane enables
//   tcnt, tcmp, tctrl   current register values for the read mux
//   match               STAT.MATCH
//   irq                 MATCH && IE, held in its own flop
module dmem_timer
    import dmem_responder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        tcnt_we,
    input  logic        tcmp_we,
    input  logic        tctrl_we,
    input  logic        stat_we,
    input  logic [31:0] wdata,
    input  logic [3:0]  wbe,
    output logic [31:0] tcnt,
    output logic [31:0] tcmp,
    output logic [2:0]  tctrl,
    output logic        match,
    output logic        irq
);

    logic [31:0] tcnt_q, tcnt_d;
    logic [31:0] tcmp_q, tcmp_d;
    logic [2:0]  tctrl_q, tctrl_d;
    logic        match_q, match_d;
    logic        irq_q, irq_d;
    logic        match_hw_s;
    logic        match_clr_s;
    logic [31:0] tctrl_wr_s;

    // Next-state for count, compare, control, match flag and interrupt.
    always_comb begin
        tcnt_d      = tcnt_q;
        tcmp_d      = tcmp_q;
        tctrl_d     = tctrl_q;
        match_d     = match_q;
        match_hw_s  = 1'b0;
        match_clr_s = 1'b0;
        tctrl_wr_s  = merge_bytes({29'd0, tctrl_q}, wdata, wbe);

        // A software load outranks both match handling and counting.
        if (tcnt_we) begin
            tcnt_d = merge_bytes(tcnt_q, wdata, wbe);
        end else if (tctrl_q[TCTRL_EN] && (tcnt_q == tcmp_q)) begin
            match_hw_s = 1'b1;
            if (tctrl_q[TCTRL_AUTO]) begin
                tcnt_d = 32'd0;
            end else begin
                tcnt_d = tcnt_q + 32'd1;
            end
        end else if (tctrl_q[TCTRL_EN]) begin
            tcnt_d = tcnt_q + 32'd1;
        end else begin
            tcnt_d = tcnt_q;
        end

        if (tcmp_we) begin
            tcmp_d = merge_bytes(tcmp_q, wdata, wbe);
        end else begin
            tcmp_d = tcmp_q;
        end

        if (tctrl_we) begin
            tctrl_d = tctrl_wr_s[2:0];
        end else begin
            tctrl_d = tctrl_q;
        end

        // Write-1-to-clear lives in byte lane 0.
        if (stat_we && wbe[0] && wdata[STAT_MATCH]) begin
            match_clr_s = 1'b1;
        end else begin
            match_clr_s = 1'b0;
        end

        // Hardware set beats a same-cycle software clear.
        if (match_hw_s) begin
            match_d = 1'b1;
        end else if (match_clr_s) begin
            match_d = 1'b0;
        end else begin
            match_d = match_q;
        end

        // Computed from next-state so irq always equals MATCH && IE.
        irq_d = match_d && tctrl_d[TCTRL_IE];
    end

    // Timer state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcnt_q  <= 32'd0;
            tcmp_q  <= 32'd0;
            tctrl_q <= 3'd0;
            match_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            tcnt_q  <= tcnt_d;
            tcmp_q  <= tcmp_d;
            tctrl_q <= tctrl_d;
            match_q <= match_d;
            irq_q   <= irq_d;
        end
    end

    assign tcnt  = tcnt_q;
    assign tcmp  = tcmp_q;
    assign tctrl = tctrl_q;
    assign match = match_q;
    assign irq   = irq_q;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
// Data-memory responder for the pipelined MIPS core: word-addressed RAM with
// byte-lane writes plus a small MMIO register bank (cycle counter, compare
// timer, status, scratch). Reads are combinational; writes commit on the
// rising edge.
// Ports:
//   clk        clock
//   rst        asynchronous active-low reset
//   dmem_addr  byte address from the core
//   dmem_din   write data
//   dmem_be    byte-lane enables, bit i covers byte [8i+7:8i]
//   dmem_wren  write request
//   dmem_dout  combinational read data
//   timer_irq  level timer interrupt
//   err        sticky access-error flag (STAT.ERR)
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [31:0] MMIO_BASE  = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_din,
    input  logic [3:0]  dmem_be,
    input  logic        dmem_wren,
    output logic [31:0] dmem_dout,
    output logic        timer_irq,
    output logic        err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [31:0]           ram_q [DEPTH];

    logic                  ready_q, ready_d;
    logic [31:0]           cycle_q, cycle_d;
    logic [31:0]           scratch_q, scratch_d;
    logic                  err_q, err_d;

    region_e               region_s;
    logic                  ram_hit_s;
    logic                  mmio_hit_s;
    logic [DEPTH_LOG2-1:0] ram_idx_s;
    logic [5:0]            off_s;
    logic                  wr_req_s;
    logic                  misalign_s;
    logic                  wr_ok_s;
    logic                  err_set_s;
    logic                  ram_we_s;
    logic                  mmio_we_s;
    logic                  stat_we_s;
    logic [31:0]           rd_data_s;

    logic [31:0]           tcnt_s;
    logic [31:0]           tcmp_s;
    logic [2:0]            tctrl_s;
    logic                  match_s;
    logic                  irq_s;

    assign ram_hit_s  = (dmem_addr[31:DEPTH_LOG2+2] == {(30-DEPTH_LOG2){1'b0}});
    assign mmio_hit_s = (dmem_addr[31:8] == MMIO_BASE[31:8]);
    assign ram_idx_s  = dmem_addr[DEPTH_LOG2+1:2];
    assign off_s      = dmem_addr[7:2];
    assign misalign_s = (dmem_addr[1:0] != 2'b00);

    // Address decode; RAM takes precedence should the windows overlap.
    always_comb begin
        region_s = REGION_NONE;
        if (ram_hit_s) begin
            region_s = REGION_RAM;
        end else if (mmio_hit_s) begin
            region_s = REGION_MMIO;
        end else begin
            region_s = REGION_NONE;
        end
    end

    // ready_q is low for the first edge after reset release, so a write that
    // lines up with the release edge is dropped. It is also low during reset.
    assign wr_req_s  = dmem_wren && (dmem_be != 4'b0000) && ready_q;
    assign wr_ok_s   = wr_req_s && !misalign_s;
    assign err_set_s = wr_req_s && (misalign_s || (region_s == REGION_NONE));
    assign ram_we_s  = wr_ok_s && (region_s == REGION_RAM);
    assign mmio_we_s = wr_ok_s && (region_s == REGION_MMIO);
    assign stat_we_s = mmio_we_s && (off_s == OFF_STAT);

    // RAM array: byte-lane writes, no reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            for (int i = 0; i < 4; i++) begin
                if (dmem_be[i]) begin
                    ram_q[ram_idx_s][8*i +: 8] <= dmem_din[8*i +: 8];
                end
            end
        end
    end

    // Next-state for cycle counter, scratch and sticky error flag.
    always_comb begin
        ready_d   = 1'b1;
        cycle_d   = cycle_q + 32'd1;
        scratch_d = scratch_q;
        err_d     = err_q;

        if (mmio_we_s && (off_s == OFF_SCRATCH)) begin
            scratch_d = merge_bytes(scratch_q, dmem_din, dmem_be);
        end else begin
            scratch_d = scratch_q;
        end

        // Hardware set beats a same-cycle write-1-to-clear.
        if (err_set_s) begin
            err_d = 1'b1;
        end else if (stat_we_s && dmem_be[0] && dmem_din[STAT_ERR]) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // Top-level register bank state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_q   <= 1'b0;
            cycle_q   <= 32'd0;
            scratch_q <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            ready_q   <= ready_d;
            cycle_q   <= cycle_d;
            scratch_q <= scratch_d;
            err_q     <= err_d;
        end
    end

    dmem_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .tcnt_we  (mmio_we_s && (off_s == OFF_TCNT)),
        .tcmp_we  (mmio_we_s && (off_s == OFF_TCMP)),
        .tctrl_we (mmio_we_s && (off_s == OFF_TCTRL)),
        .stat_we  (stat_we_s),
        .wdata    (dmem_din),
        .wbe      (dmem_be),
        .tcnt     (tcnt_s),
        .tcmp     (tcmp_s),
        .tctrl    (tctrl_s),
        .match    (match_s),
        .irq      (irq_s)
    );

    // Combinational read mux; addr[1:0] plays no part in reads.
    always_comb begin
        rd_data_s = 32'd0;
        case (region_s)
            REGION_RAM: begin
                rd_data_s = ram_q[ram_idx_s];
            end
            REGION_MMIO: begin
                case (off_s)
                    OFF_CYCLE:   rd_data_s = cycle_q;
                    OFF_TCNT:    rd_data_s = tcnt_s;
                    OFF_TCMP:    rd_data_s = tcmp_s;
                    OFF_TCTRL:   rd_data_s = {29'd0, tctrl_s};
                    OFF_STAT:    rd_data_s = {30'd0, err_q, match_s};
                    OFF_SCRATCH: rd_data_s = scratch_q;
                    default:     rd_data_s = 32'd0;
                endcase
            end
            default: begin
                rd_data_s = 32'd0;
            end
        endcase
    end

    assign dmem_dout = rd_data_s;
    assign timer_irq = irq_s;
    assign err       = err_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder for the pipelined MIPS core's data interface (dmem_addr/din/be/wren/dout).
- Holds a word-addressed RAM with byte-lane writes.
- Holds a small memory-mapped register bank: free-running cycle counter, compare timer with interrupt, scratch register.
- Reads are combinational, so the core samples dmem_dout in the same cycle it drives the address. Writes commit on the rising clock edge.

Parameters:
- DEPTH_LOG2, 10, RAM depth as log2 of 32-bit words (1024 words = 4 KiB at byte address 0).
- MMIO_BASE, 32'h0000_7F00, byte base of the register bank; 256-byte window, only bits [31:8] compared.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- dmem_addr  input  32  byte address from core.
- dmem_din  input  32  write data.
- dmem_be  input  4  byte-lane enables; bit i = byte [8i+7:8i].
- dmem_wren  input  1  write request for this cycle.
- dmem_dout  output  32  read data, combinational from dmem_addr and current state.
- timer_irq  output  1  timer interrupt, level, registered-state derived.
- err  output  1  sticky access-error flag.

Behaviour:
Address decode (on dmem_addr):
- RAM hit: addr < 4*2^DEPTH_LOG2; word index = addr[DEPTH_LOG2+1:2].
- MMIO hit: addr[31:8] == MMIO_BASE[31:8]; offset = addr[7:2].
- Otherwise unmapped: dout = 0; write ignored; if wren && be != 0, err set.
- addr[1:0] ignored for reads. If wren && be != 0 && addr[1:0] != 0, the write is dropped and err is set.
- be = 4'b0000 with wren = 1 is a no-op: no write, no error.

RAM:
- Each enabled byte lane is written at the edge.
- Read returns pre-edge contents; a write becomes visible the following cycle.
- Contents are not cleared by reset (unwritten = don't-care).

MMIO map (word offsets ×4):
- 0x00 CYCLE: read-only 32-bit counter, +1 every cycle, wraps 0xFFFF_FFFF -> 0. Writes ignored, no error.
- 0x04 TCNT: RW timer count.
- 0x08 TCMP: RW compare value.
- 0x0C TCTRL: bit0 EN, bit1 AUTO (reload), bit2 IE (irq enable); other bits read 0.
- 0x10 STAT: bit0 MATCH, bit1 ERR; write-1-to-clear per bit.
- 0x14 SCRATCH: RW.
- Other offsets read 0; writes ignored, no error.
- Byte enables apply to all RW registers.

Timer (per cycle, priority high to low):
- Software write to TCNT loads the written lanes; the increment is suppressed that cycle.
- Else if EN && TCNT == TCMP: MATCH <= 1; TCNT <= AUTO ? 0 : TCNT+1.
- Else if EN: TCNT <= TCNT+1, wraps at 2^32.
- EN = 0 freezes TCNT; no match detection.
- Same-cycle W1C clear and hardware set of MATCH (or ERR): set wins.

Outputs and reset:
- timer_irq = MATCH && IE.
- err = STAT.ERR.
- rst low: CYCLE, TCNT, TCMP, TCTRL, STAT, SCRATCH cleared to 0 immediately.
- While rst low: timer_irq = 0, err = 0, no writes commit.
- After release: CYCLE reads 0 in the first cycle, then counts.
- A write coinciding with the reset-release edge is dropped.

Decomposition:
- Shared define file dmem_map_def.v (included like the existing ctrl/instruction define files):
  - MMIO offset constants (CYCLE/TCNT/TCMP/TCTRL/STAT/SCRATCH).
  - TCTRL bit positions (EN, AUTO, IE).
  - STAT bit positions (MATCH, ERR).
- Sub-module dmem_timer: TCNT/TCMP/TCTRL/MATCH plus irq logic, with byte-lane write ports. RAM array, decode, CYCLE, SCRATCH, ERR and read mux stay in the top.

Test Plan:
1. RAM byte lanes:
   - Write 0x11223344, be=1111 to 0x40, then 0xAABBCCDD with be=0101 to 0x40.
   - Read 0x40 -> 0x11BB33DD; read in the write cycle still returns the old value.
2. Errors:
   - Write be=1111 to 0x42 -> RAM at 0x40 unchanged, err=1.
   - Write to 0x0010_0000 -> err stays 1; reads there return 0.
   - Write 0x2 to STAT -> err=0 next cycle.
3. Auto-reload timer:
   - TCMP=3, TCTRL=0x7.
   - TCNT sequence 0,1,2,3,0,1…; MATCH and timer_irq rise the cycle after TCNT==3.
   - Write 1 to STAT -> irq drops next cycle, re-asserts at the next match.
4. Priority:
   - Same-cycle W1C of MATCH and a hardware match -> MATCH stays 1.
   - TCNT write of 0x100 during EN -> next read 0x100, not 0x101.
   - TCTRL=0x1 (no AUTO, IE=0), TCMP=TCNT -> TCNT keeps counting past match; timer_irq stays 0.
5. CYCLE: write to CYCLE ignored; two reads N cycles apart differ by N; wrap checked from a forced 0xFFFF_FFFE.
6. Async reset:
   - Drive rst low mid-count, between edges -> all registers 0, timer_irq=0, err=0 immediately.
   - RAM contents written before reset are still readable after release.
